// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its prefetch FIFO.
package instruction_fetch_pkg;

  localparam int               IF_INS_LEN  = 54;
  localparam int               IF_DEPTH    = 4;
  localparam int               OPCODE_W    = 4;
  localparam logic [3:0]       IF_HALT_OP  = 4'hF;
  localparam int               ICACHE_ROWS = 1024;
  localparam int               ICACHE_AW   = 10;
  localparam int               CNT_W       = 11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } ifetch_state_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO buffering prefetched {pc, instruction} words.
module instruction_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; an entry is only meaningful while count_q covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Sequences icache control-port reads from a start row into a prefetch FIFO and
// hands instructions to the decoder; a run ends on a programmed count or a HALT opcode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  INS_LEN = IF_INS_LEN,
  parameter int                  DEPTH   = IF_DEPTH,
  parameter logic [OPCODE_W-1:0] HALT_OP = IF_HALT_OP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ICACHE_AW-1:0] start_addr,
  input  logic [CNT_W-1:0]     ins_count,
  input  logic                 flush,
  output logic                 icache_rd_ctrl_en,
  output logic [ICACHE_AW-1:0] icache_rd_ctrl_addr,
  input  logic [INS_LEN-1:0]   icache_rd_ctrl_data,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_LEN-1:0]   ins_data,
  output logic [ICACHE_AW-1:0] ins_pc,
  output logic                 busy,
  output logic                 done
);

  localparam int FW = ICACHE_AW + INS_LEN;
  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_t        state_q, state_d;
  logic [ICACHE_AW-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 rd_en, pop;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [FW-1:0]        head;
  logic                 halt_word;

  assign halt_word = (icache_rd_ctrl_data[INS_LEN-1 -: OPCODE_W] == HALT_OP);
  assign pop       = ins_valid && ins_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        pc_d    = start_addr;
        rem_d   = ins_count;
        state_d = (ins_count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        rd_en = !fifo_full;
        if (rd_en) begin
          pc_d  = pc_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1) || halt_word) state_d = DRAIN;
        end
      end
      // Leave as the last word is popped so done lands the cycle after that pop.
      DRAIN: if (fifo_empty || (fifo_count == CW'(1) && pop)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      pc_d    = pc_q;
      rem_d   = rem_q;
      rd_en   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
    end
  end

  instruction_fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rd_en),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({pc_q, icache_rd_ctrl_data}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign icache_rd_ctrl_en   = rd_en;
  assign icache_rd_ctrl_addr = pc_q;
  assign ins_valid           = !fifo_empty;
  assign ins_data            = head[INS_LEN-1:0];
  assign ins_pc              = head[FW-1 -: ICACHE_AW];
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench: icache array model, expected-word queue built from start/count/HALT rules.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int W     = IF_INS_LEN;
  localparam int DEPTH = IF_DEPTH;

  logic                 clk, rst_n, start, flush, ins_ready;
  logic [ICACHE_AW-1:0] start_addr;
  logic [CNT_W-1:0]     ins_count;
  logic                 icache_rd_ctrl_en;
  logic [ICACHE_AW-1:0] icache_rd_ctrl_addr;
  logic [W-1:0]         icache_rd_ctrl_data;
  logic                 ins_valid;
  logic [W-1:0]         ins_data;
  logic [ICACHE_AW-1:0] ins_pc;
  logic                 busy, done;

  instruction_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .start_addr          (start_addr),
    .ins_count           (ins_count),
    .flush               (flush),
    .icache_rd_ctrl_en   (icache_rd_ctrl_en),
    .icache_rd_ctrl_addr (icache_rd_ctrl_addr),
    .icache_rd_ctrl_data (icache_rd_ctrl_data),
    .ins_valid           (ins_valid),
    .ins_ready           (ins_ready),
    .ins_data            (ins_data),
    .ins_pc              (ins_pc),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] icache [ICACHE_ROWS];
  assign icache_rd_ctrl_data = icache[icache_rd_ctrl_addr];

  typedef struct packed {
    logic [ICACHE_AW-1:0] pc;
    logic [W-1:0]         ins;
  } item_t;

  item_t                exp_q[$];
  logic [ICACHE_AW-1:0] rd_q[$];

  int n_checks = 0, n_pass = 0, cyc = 0;
  int occ = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1, last_pop_cyc = -1;
  logic                 hold_v = 1'b0;
  logic [W-1:0]         hold_d;
  logic [ICACHE_AW-1:0] hold_pc;
  bit                   mon_on, mon_clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic rv(input int c, input int hold, input int pct);
    return (c >= hold) && (int'($urandom_range(99)) < pct);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: reads must follow the expected row order, pops must match the expected words.
  always @(negedge clk) begin : mon
    item_t it;
    if (mon_clr) begin
      occ = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; hold_v = 1'b0;
    end
    if (mon_on) begin
      if (icache_rd_ctrl_en) begin
        check("read_room", occ < DEPTH, 1);
        check("read_pending", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) check("read_addr", icache_rd_ctrl_addr, rd_q.pop_front());
        rd_cnt++;
      end
      if (hold_v) begin
        check("hold_valid", ins_valid, 1);
        check("hold_data", ins_data, hold_d);
        check("hold_pc", ins_pc, hold_pc);
      end
      hold_v  = ins_valid && !ins_ready;
      hold_d  = ins_data;
      hold_pc = ins_pc;
      if (ins_valid && ins_ready) begin
        check("pop_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          it = exp_q.pop_front();
          check("ins_pc", ins_pc, it.pc);
          check("ins_data", ins_data, it.ins);
        end
        last_pop_cyc = cyc;
      end
      occ = occ + int'(icache_rd_ctrl_en) - int'(ins_valid && ins_ready);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic build(input logic [ICACHE_AW-1:0] addr, input int cnt, output int len);
    logic [ICACHE_AW-1:0] row;
    len = 0;
    for (int i = 0; i < cnt; i++) begin
      row = addr + ICACHE_AW'(i);
      exp_q.push_back('{pc: row, ins: icache[row]});
      rd_q.push_back(row);
      len++;
      if (icache[row][W-1 -: OPCODE_W] == IF_HALT_OP) break;
    end
  endtask

  task automatic run(input logic [ICACHE_AW-1:0] addr, input int cnt, input int pct, input int hold);
    int len, c, budget, start_cyc;
    build(addr, cnt, len);
    budget = 8 * cnt + 40 + hold;
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; ins_count = CNT_W'(cnt);
    ins_ready = rv(0, hold, pct); mon_clr = 1'b1;
    c = 0;
    forever begin
      @(negedge clk); #1;
      if (c == 0) begin
        start_cyc = cyc;
        check("c0_no_read", icache_rd_ctrl_en, 0);
      end
      if (c == 1) begin
        if (cnt > 0) check("c1_read", icache_rd_ctrl_en, 1);
        else begin
          check("zero_no_read", icache_rd_ctrl_en, 0);
          check("zero_done", done, 1);
        end
      end
      if (c == 2 && cnt > 0) check("c2_valid", ins_valid, 1);
      if (hold > 0 && c == hold - 1) check("hold_reads", rd_cnt, (len < DEPTH) ? len : DEPTH);
      if (done_cnt > 0 || c >= budget) break;
      @(posedge clk); #1;
      c++;
      mon_clr = 1'b0;
      start = (c == 2 && cnt > 0);
      if (start) begin
        start_addr = ICACHE_AW'($urandom);
        ins_count  = CNT_W'($urandom_range(1, 50));
      end
      ins_ready = rv(c, hold, pct);
    end
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    @(negedge clk); #1;
    check("done_once", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("exp_drained", exp_q.size(), 0);
    check("reads_done", rd_q.size(), 0);
    if (cnt > 0) check("done_after_pop", done_cyc, last_pop_cyc + 1);
    else         check("zero_done_cyc", done_cyc, start_cyc + 1);
    if (cnt > 0 && hold == 0 && pct == 100) check("throughput", done_cyc - start_cyc, len + 2);
  endtask

  task automatic flush_test();
    int len;
    build(10'd300, 20, len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 10'd300; ins_count = 11'd20; ins_ready = 1'b0; mon_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_occ", occ, 3);
    flush = 1'b1; start = 1'b1; start_addr = 10'd500; ins_count = 11'd5; ins_ready = 1'b1;
    @(negedge clk); #1;
    check("flush_no_read", icache_rd_ctrl_en, 0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    exp_q.delete(); rd_q.delete(); mon_clr = 1'b1;
    @(negedge clk); #1;
    check("flush_empty", ins_valid, 0);
    check("flush_idle", busy, 0);
    check("flush_no_read2", icache_rd_ctrl_en, 0);
    @(posedge clk); #1;
    mon_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_done", done_cnt, 0);
  endtask

  initial begin
    logic [ICACHE_AW-1:0] r;
    int cnt;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; ins_ready = 1'b0;
    start_addr = '0; ins_count = '0; mon_on = 1'b0; mon_clr = 1'b0;
    for (int i = 0; i < ICACHE_ROWS; i++) begin
      icache[i] = W'({$urandom, $urandom});
      if (icache[i][W-1 -: OPCODE_W] == IF_HALT_OP) icache[i][W-1] = 1'b0;
    end

    repeat (2) @(negedge clk);
    check("rst_en", icache_rd_ctrl_en, 0);
    check("rst_addr", icache_rd_ctrl_addr, 0);
    check("rst_valid", ins_valid, 0);
    check("rst_data", ins_data, 0);
    check("rst_pc", ins_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_on = 1'b1;

    run(10'd0, 8, 100, 0);
    run(10'd1022, 4, 100, 0);
    run(10'd100, 16, 100, 10);
    icache[5][W-1 -: OPCODE_W] = IF_HALT_OP;
    run(10'd3, 100, 100, 0);
    flush_test();
    run(10'd200, 6, 100, 0);
    run(10'd50, 0, 100, 0);

    for (int it = 0; it < 20; it++) begin
      r   = ICACHE_AW'($urandom);
      cnt = $urandom_range(1, 40);
      if ($urandom_range(3) == 0)
        icache[r + ICACHE_AW'($urandom_range(0, cnt - 1))][W-1 -: OPCODE_W] = IF_HALT_OP;
      run(r, cnt, (it % 3 == 0) ? 100 : ((it % 3 == 1) ? 70 : 40), (it % 4 == 1) ? 6 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
